// File: rtl/unified_mem_ctrl.sv
// Unified byte-addressable instruction/data memory: combinational fetch port plus a
// handshaked, wait-stated data port. Optional store protection: UMEM_WRITE_PROTECT_EN.
module unified_mem_ctrl #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_WAIT  = 0,
  parameter int unsigned BIG_ENDIAN = 1,
  parameter int unsigned RO_LIMIT   = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o,
  output logic            if_misalign_o,
  input  logic            d_req_i,
  output logic            d_ready_o,
  input  logic            d_we_i,
  input  logic [1:0]      d_size_i,
  input  logic            d_unsigned_i,
  input  logic [XLEN-1:0] d_addr_i,
  input  logic [XLEN-1:0] d_wdata_i,
  output logic            d_rvalid_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            d_err_o
);

  localparam bit BE = (BIG_ENDIAN != 0);
  localparam int unsigned MEM_BYTES = 1 << ADDR_W;
  localparam logic [XLEN-1:0] RO_ADDR = XLEN'(RO_LIMIT);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [7:0] mem [MEM_BYTES];

  // Maps a byte offset within a word to its byte lane (lane 0 = bits 7:0).
  function automatic logic [1:0] lane(input logic [1:0] off);
    return BE ? ~off : off;
  endfunction

  // ---------------- fetch port ----------------
  logic [XLEN-1:0] f_word;

  always_comb begin
    f_word = '0;
    for (int unsigned k = 0; k < 4; k++)
      f_word[{lane(2'(k)), 3'b000} +: 8] = mem[{if_addr_i[ADDR_W-1:2], 2'(k)}];
  end

  assign pc_o          = if_addr_i;
  assign inst_o        = f_word;
  assign if_misalign_o = |if_addr_i[1:0];

  // ---------------- data port control ----------------
  state_t            state, state_nx;
  logic [2:0]        cnt, cnt_nx;
  logic              commit;
  logic              cap_we, cap_uns;
  logic [1:0]        cap_size;
  logic [ADDR_W-1:0] cap_addr;
  logic [XLEN-1:0]   cap_wdata;

  assign d_ready_o = (state == IDLE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (d_req_i) begin
          if (DATA_WAIT == 0) begin
            commit = 1'b1;
          end else begin
            state_nx = BUSY;
            cnt_nx   = 3'(DATA_WAIT);
          end
        end
      end
      BUSY: begin
        cnt_nx = cnt - 3'd1;
        if (cnt == 3'd1) begin
          commit   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_uns   <= 1'b0;
      cap_size  <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && d_req_i) begin
        cap_we    <= d_we_i;
        cap_uns   <= d_unsigned_i;
        cap_size  <= d_size_i;
        cap_addr  <= d_addr_i[ADDR_W-1:0];
        cap_wdata <= d_wdata_i;
      end
    end
  end

  // ---------------- access datapath ----------------
  // Zero-wait commits straight from the port; otherwise from the captured request.
  logic              cur_we, cur_uns;
  logic [1:0]        cur_size, bsel;
  logic [ADDR_W-1:0] cur_addr;
  logic [XLEN-1:0]   cur_wdata;
  logic              misalign, protect, acc_err;
  logic [XLEN-1:0]   r_word, w_word, ld_val;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [3:0]        w_lanes;

  always_comb begin
    if (state == BUSY) begin
      cur_we = cap_we; cur_uns = cap_uns; cur_size = cap_size;
      cur_addr = cap_addr; cur_wdata = cap_wdata;
    end else begin
      cur_we = d_we_i; cur_uns = d_unsigned_i; cur_size = d_size_i;
      cur_addr = d_addr_i[ADDR_W-1:0]; cur_wdata = d_wdata_i;
    end
  end

  always_comb begin
    bsel     = lane(cur_addr[1:0]);
    misalign = (cur_size == 2'b11) ||
               (cur_size == 2'b01 && cur_addr[0]) ||
               (cur_size == 2'b10 && cur_addr[1:0] != 2'b00);
`ifdef UMEM_WRITE_PROTECT_EN
    protect  = cur_we && (XLEN'(cur_addr) < RO_ADDR);
`else
    protect  = 1'b0;
`endif
    acc_err  = misalign || protect;

    r_word = '0;
    for (int unsigned k = 0; k < 4; k++)
      r_word[{lane(2'(k)), 3'b000} +: 8] = mem[{cur_addr[ADDR_W-1:2], 2'(k)}];
    ld_byte = r_word[{bsel, 3'b000} +: 8];
    ld_half = r_word[{bsel[1], 4'b0000} +: 16];

    case (cur_size)
      2'b00:   ld_val = {{(XLEN-8){ld_byte[7] & ~cur_uns}}, ld_byte};
      2'b01:   ld_val = {{(XLEN-16){ld_half[15] & ~cur_uns}}, ld_half};
      default: ld_val = r_word;
    endcase

    // Replicate store data across lanes; the lane mask picks the addressed bytes.
    case (cur_size)
      2'b00: begin
        w_word  = {4{cur_wdata[7:0]}};
        w_lanes = 4'b0001 << bsel;
      end
      2'b01: begin
        w_word  = {2{cur_wdata[15:0]}};
        w_lanes = bsel[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_word  = cur_wdata;
        w_lanes = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (commit && cur_we && !acc_err && !rst_i) begin
      for (int unsigned k = 0; k < 4; k++)
        if (w_lanes[lane(2'(k))])
          mem[{cur_addr[ADDR_W-1:2], 2'(k)}] <= w_word[{lane(2'(k)), 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_rvalid_o <= 1'b0;
      d_rdata_o  <= '0;
      d_err_o    <= 1'b0;
    end else begin
      d_rvalid_o <= commit;
      if (commit) begin
        d_err_o   <= acc_err;
        d_rdata_o <= (acc_err || cur_we) ? '0 : ld_val;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{d_addr_i[XLEN-1:ADDR_W], RO_ADDR};

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Bench for unified_mem_ctrl: directed table on a zero-wait big-endian instance, timing and
// reset corner sequences plus randomized traffic on a 3-wait little-endian instance.
module tb_unified_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        d_we, d_uns, req_a, req_b;
  logic [1:0]  d_size;

  logic [31:0] a_pc, a_inst, a_rdata, b_pc, b_inst, b_rdata;
  logic        a_ifmis, a_ready, a_rvalid, a_err, b_ifmis, b_ready, b_rvalid, b_err;

  always #5 clk = ~clk;

  unified_mem_ctrl #(.XLEN(32), .ADDR_W(12), .DATA_WAIT(0), .BIG_ENDIAN(1), .RO_LIMIT(0)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .if_addr_i(if_addr), .pc_o(a_pc), .inst_o(a_inst),
    .if_misalign_o(a_ifmis), .d_req_i(req_a), .d_ready_o(a_ready), .d_we_i(d_we),
    .d_size_i(d_size), .d_unsigned_i(d_uns), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rvalid_o(a_rvalid), .d_rdata_o(a_rdata), .d_err_o(a_err));

  unified_mem_ctrl #(.XLEN(32), .ADDR_W(12), .DATA_WAIT(3), .BIG_ENDIAN(0), .RO_LIMIT(32'h200)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .if_addr_i(if_addr), .pc_o(b_pc), .inst_o(b_inst),
    .if_misalign_o(b_ifmis), .d_req_i(req_b), .d_ready_o(b_ready), .d_we_i(d_we),
    .d_size_i(d_size), .d_unsigned_i(d_uns), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rvalid_o(b_rvalid), .d_rdata_o(b_rdata), .d_err_o(b_err));

`ifdef UMEM_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  // Reference memories: index 0 = big-endian instance, 1 = little-endian instance.
  bit [7:0] ref_mem [2][4096];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input int d, input bit we, input bit [1:0] sz, input bit uns,
                                input bit [31:0] addr, input bit [31:0] wd,
                                output bit err, output bit [31:0] rd);
    int n, sh;
    bit [11:0] a;
    bit [31:0] v;
    a = addr[11:0];
    n = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    err = (sz == 3) || (a % n != 0);
    if (PROT && d == 1 && we && a < 12'h200) err = 1'b1;
    rd = 0;
    if (err) return;
    v = 0;
    for (int i = 0; i < n; i++) begin
      sh = (d == 0) ? 8 * (n - 1 - i) : 8 * i;
      if (we) ref_mem[d][a + i] = wd[sh +: 8];
      else    v |= 32'(ref_mem[d][a + i]) << sh;
    end
    if (!we) begin
      if (!uns && n == 1)      v = {{24{v[7]}}, v[7:0]};
      else if (!uns && n == 2) v = {{16{v[15]}}, v[15:0]};
      rd = v;
    end
  endfunction

  function automatic bit [31:0] mword(input int d, input bit [31:0] addr);
    bit [31:0] v;
    int base;
    base = {20'd0, addr[11:2], 2'b00};
    v = 0;
    for (int i = 0; i < 4; i++)
      v |= 32'(ref_mem[d][base + i]) << ((d == 0) ? 8 * (3 - i) : 8 * i);
    return v;
  endfunction

  task automatic txn(input int d, input bit we, input bit [1:0] sz, input bit uns,
                     input bit [31:0] addr, input bit [31:0] wd,
                     output bit rv, output bit [31:0] rd, output bit er, output int lat);
    d_we = we; d_size = sz; d_uns = uns; d_addr = addr; d_wdata = wd;
    if (d == 0) req_a = 1'b1; else req_b = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
    lat = 1;
    while (!((d == 0) ? a_rvalid : b_rvalid) && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    rv = (d == 0) ? a_rvalid : b_rvalid;
    rd = (d == 0) ? a_rdata : b_rdata;
    er = (d == 0) ? a_err : b_err;
  endtask

  typedef struct {
    bit        we;
    bit [1:0]  sz;
    bit        uns;
    bit [31:0] addr;
    bit [31:0] wd;
    bit [31:0] exp_rd;
    bit        exp_err;
    bit [31:0] exp_inst;
  } vec_t;

  vec_t tbl [16];

  initial begin
    bit rv, er, m_err, saw;
    bit [31:0] rd, m_rd, addr, wd;
    bit [1:0] sz;
    int lat, d;

    tbl[0]  = '{1, 2'd2, 0, 32'h100,  32'h11223344, 32'h00000000, 0, 32'h11223344};
    tbl[1]  = '{0, 2'd2, 0, 32'h100,  32'h0,        32'h11223344, 0, 32'h11223344};
    tbl[2]  = '{0, 2'd0, 0, 32'h103,  32'h0,        32'h00000044, 0, 32'h11223344};
    tbl[3]  = '{1, 2'd0, 0, 32'h101,  32'hABCDEFF0, 32'h00000000, 0, 32'h11F03344};
    tbl[4]  = '{0, 2'd0, 0, 32'h101,  32'h0,        32'hFFFFFFF0, 0, 32'h11F03344};
    tbl[5]  = '{0, 2'd0, 1, 32'h101,  32'h0,        32'h000000F0, 0, 32'h11F03344};
    tbl[6]  = '{0, 2'd1, 0, 32'h100,  32'h0,        32'h000011F0, 0, 32'h11F03344};
    tbl[7]  = '{0, 2'd1, 0, 32'h101,  32'h0,        32'h00000000, 1, 32'h11F03344};
    tbl[8]  = '{1, 2'd2, 0, 32'h102,  32'hDEADBEEF, 32'h00000000, 1, 32'h11F03344};
    tbl[9]  = '{0, 2'd3, 0, 32'h100,  32'h0,        32'h00000000, 1, 32'h11F03344};
    tbl[10] = '{0, 2'd2, 0, 32'h100,  32'h0,        32'h11F03344, 0, 32'h11F03344};
    tbl[11] = '{1, 2'd1, 0, 32'h102,  32'h1234ABCD, 32'h00000000, 0, 32'h11F0ABCD};
    tbl[12] = '{0, 2'd1, 0, 32'h102,  32'h0,        32'hFFFFABCD, 0, 32'h11F0ABCD};
    tbl[13] = '{0, 2'd1, 1, 32'h102,  32'h0,        32'h0000ABCD, 0, 32'h11F0ABCD};
    tbl[14] = '{0, 2'd2, 0, 32'h1100, 32'h0,        32'h11F0ABCD, 0, 32'h11F0ABCD};
    tbl[15] = '{1, 2'd3, 0, 32'h100,  32'h55555555, 32'h00000000, 1, 32'h11F0ABCD};

    rst = 1'b1; req_a = 0; req_b = 0; d_we = 0; d_size = 0; d_uns = 0;
    d_addr = 0; d_wdata = 0; if_addr = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset a_rvalid", 32'(a_rvalid), 0);
    check("reset a_rdata", a_rdata, 0);
    check("reset a_err", 32'(a_err), 0);
    check("reset a_ready", 32'(a_ready), 1);
    check("reset b_rvalid", 32'(b_rvalid), 0);
    check("reset b_rdata", b_rdata, 0);
    check("reset b_ready", 32'(b_ready), 1);

    // Directed table, zero-wait big-endian instance
    for (int i = 0; i < 16; i++) begin
      if_addr = 32'h100;
      #1;
      if (i > 0) check($sformatf("tbl%0d inst before commit", i), a_inst, tbl[i-1].exp_inst);
      model(0, tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, m_err, m_rd);
      txn(0, tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, rv, rd, er, lat);
      check($sformatf("tbl%0d rvalid", i), 32'(rv), 1);
      check($sformatf("tbl%0d latency", i), lat, 1);
      check($sformatf("tbl%0d rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d err", i), 32'(er), 32'(tbl[i].exp_err));
      check($sformatf("tbl%0d inst", i), a_inst, tbl[i].exp_inst);
    end
    if_addr = 32'h102; #1;
    check("pc follows if_addr", a_pc, 32'h102);
    check("if_misalign set", 32'(a_ifmis), 1);
    if_addr = 32'h1100; #1;
    check("fetch wraps", a_inst, 32'h11F0ABCD);
    check("if_misalign clear", 32'(a_ifmis), 0);

    // Wait-state timing: load at E0, second request held and accepted once IDLE
    model(1, 1, 2'd2, 0, 32'h300, 32'hA1B2C3D4, m_err, m_rd);
    txn(1, 1, 2'd2, 0, 32'h300, 32'hA1B2C3D4, rv, rd, er, lat);
    check("b store latency", lat, 4);
    d_we = 0; d_size = 2'd2; d_uns = 0; d_addr = 32'h300; req_b = 1;
    check("b ready before E0", 32'(b_ready), 1);
    @(posedge clk); #1;
    d_size = 2'd0; d_uns = 1; d_addr = 32'h301;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("busy ready c%0d", c), 32'(b_ready), 0);
      check($sformatf("busy rvalid c%0d", c), 32'(b_rvalid), 0);
      @(posedge clk); #1;
    end
    check("wait rvalid", 32'(b_rvalid), 1);
    check("wait rdata LE word", b_rdata, 32'hA1B2C3D4);
    check("ready after commit", 32'(b_ready), 1);
    @(posedge clk); #1;
    check("second accepted", 32'(b_ready), 0);
    check("rvalid one cycle", 32'(b_rvalid), 0);
    check("rdata held", b_rdata, 32'hA1B2C3D4);
    req_b = 0;
    repeat (3) @(posedge clk);
    #1;
    check("second rvalid", 32'(b_rvalid), 1);
    check("second LBU LE", b_rdata, 32'h000000C3);

    // Reset during BUSY aborts the store
    model(1, 1, 2'd2, 0, 32'h304, 32'h55667788, m_err, m_rd);
    txn(1, 1, 2'd2, 0, 32'h304, 32'h55667788, rv, rd, er, lat);
    txn(1, 0, 2'd2, 0, 32'h300, 32'h0, rv, rd, er, lat);
    check("pre-reset load", rd, 32'hA1B2C3D4);
    d_we = 1; d_size = 2'd2; d_addr = 32'h304; d_wdata = 32'h99999999; req_b = 1;
    @(posedge clk); #1;
    req_b = 0;
    @(posedge clk); #2;
    rst = 1'b1; #2;
    check("async reset rdata", b_rdata, 0);
    check("async reset rvalid", 32'(b_rvalid), 0);
    check("async reset err", 32'(b_err), 0);
    #2 rst = 1'b0;
    saw = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (b_rvalid) saw = 1;
    end
    check("no response after abort", 32'(saw), 0);
    check("ready after abort", 32'(b_ready), 1);
    txn(1, 0, 2'd2, 0, 32'h304, 32'h0, rv, rd, er, lat);
    check("aborted store not written", rd, 32'h55667788);

    // Write protection boundary (little-endian instance, RO_LIMIT = 0x200)
    model(1, 1, 2'd2, 0, 32'h1FC, 32'h12345678, m_err, m_rd);
    txn(1, 1, 2'd2, 0, 32'h1FC, 32'h12345678, rv, rd, er, lat);
    check("store below limit err", 32'(er), 32'(PROT));
    model(1, 1, 2'd2, 0, 32'h200, 32'hCAFEF00D, m_err, m_rd);
    txn(1, 1, 2'd2, 0, 32'h200, 32'hCAFEF00D, rv, rd, er, lat);
    check("store at limit err", 32'(er), 0);
    txn(1, 0, 2'd2, 0, 32'h200, 32'h0, rv, rd, er, lat);
    check("store at limit data", rd, 32'hCAFEF00D);
    if (!PROT) begin
      txn(1, 0, 2'd2, 0, 32'h1FC, 32'h0, rv, rd, er, lat);
      check("unprotected store data", rd, 32'h12345678);
    end

    // Randomized traffic against the reference model
    for (int w = 0; w < 16; w++) begin
      for (int dd = 0; dd < 2; dd++) begin
        wd = $urandom;
        model(dd, 1, 2'd2, 0, 32'h400 + 32'(w * 4), wd, m_err, m_rd);
        txn(dd, 1, 2'd2, 0, 32'h400 + 32'(w * 4), wd, rv, rd, er, lat);
      end
    end
    for (int n = 0; n < 240; n++) begin
      d = (n % 4 == 3) ? 1 : 0;
      sz = 2'($urandom_range(0, 3));
      addr = 32'h400 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 3)) << 12);
      wd = $urandom;
      rv = 1'($urandom_range(0, 1));
      model(d, rv, sz, 1'($urandom_range(0, 1)) & 1'b0, addr, wd, m_err, m_rd);
      txn(d, rv, sz, 1'b0, addr, wd, rv, rd, er, lat);
      check($sformatf("rnd%0d rvalid", n), 32'(rv), 1);
      check($sformatf("rnd%0d latency", n), lat, (d == 0) ? 1 : 4);
      check($sformatf("rnd%0d rdata", n), rd, m_rd);
      check($sformatf("rnd%0d err", n), 32'(er), 32'(m_err));
      if_addr = 32'h400 + 32'($urandom_range(0, 63));
      #1;
      check($sformatf("rnd%0d a_inst", n), a_inst, mword(0, if_addr));
      check($sformatf("rnd%0d b_inst", n), b_inst, mword(1, if_addr));
      check($sformatf("rnd%0d if_misalign", n), 32'(b_ifmis), 32'(if_addr[1:0] != 2'b00));
    end
    for (int n = 0; n < 60; n++) begin
      d = n % 2;
      sz = 2'($urandom_range(0, 1));
      addr = 32'h400 + 32'($urandom_range(0, 63));
      model(d, 1'b0, sz, 1'b1, addr, 32'h0, m_err, m_rd);
      txn(d, 1'b0, sz, 1'b1, addr, 32'h0, rv, rd, er, lat);
      check($sformatf("uns%0d rdata", n), rd, m_rd);
      check($sformatf("uns%0d err", n), 32'(er), 32'(m_err));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
